operand_loader: RTL
===================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits; frame length FRAME = 2*WIDTH+1.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin capturing one serial frame.
REQ-005 ser_in  input  1  serial data bit, sampled on rising clk while in SHIFT.
REQ-006 ack  input  1  downstream adder stage accepts the presented operands.
REQ-007 nibbl1  output  WIDTH  first operand to the adder stage.
REQ-008 nibbl2  output  WIDTH  second operand to the adder stage.
REQ-009 CIN  output  1  carry-in to the adder stage.
REQ-010 valid  output  1  nibbl1/nibbl2/CIN hold a complete, stable frame.
REQ-011 busy  output  1  a frame capture is in progress.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, HOLD.
REQ-013 IDLE -> SHIFT on a clk edge with start=1; start=0 keeps IDLE.
REQ-014 In SHIFT, each clk edge SHALL sample ser_in into an internal FRAME-bit shift register and increment a bit counter (0..FRAME-1).
REQ-015 Bit order SHALL be: bits 0..WIDTH-1 -> nibbl1[0]..nibbl1[WIDTH-1] (LSB first), bits WIDTH..2*WIDTH-1 -> nibbl2[0]..nibbl2[WIDTH-1], bit 2*WIDTH -> CIN.
REQ-016 SHIFT -> HOLD on the edge sampling bit FRAME-1; the counter SHALL return to 0 on that edge.
REQ-017 nibbl1, nibbl2, CIN SHALL update only on the SHIFT -> HOLD edge (parallel load from the shift register plus the final bit); they SHALL NOT ripple during SHIFT.
REQ-018 Latency: valid SHALL be 1 in the cycle after the edge on which the final bit was sampled, i.e. FRAME cycles after the start edge.
REQ-019 In HOLD, valid=1 and outputs SHALL remain stable until ack=1 is sampled; HOLD -> IDLE on that edge, and valid SHALL be 0 from the next cycle.
REQ-020 After HOLD -> IDLE, nibbl1/nibbl2/CIN SHALL retain the last frame (not cleared).
REQ-021 busy SHALL be 1 exactly while in SHIFT.
REQ-022 start asserted in SHIFT or HOLD SHALL be ignored (no restart, no counter change).
REQ-023 ack asserted in IDLE or SHIFT SHALL be ignored.
REQ-024 start and ack both 1 in HOLD: ack takes effect (-> IDLE); start is ignored and a new frame needs start in IDLE.
REQ-025 Holding start=1 continuously SHALL re-enter SHIFT on the first edge after returning to IDLE (one idle cycle between frames).

Reset
REQ-026 rst=1 SHALL immediately, independent of clk, force state=IDLE, counter=0, shift register=0, nibbl1=0, nibbl2=0, CIN=0, valid=0, busy=0.
REQ-027 Reset asserted mid-SHIFT or in HOLD SHALL discard the partial/pending frame; no output SHALL reflect partial data after rst deasserts.
REQ-028 On the first clk edge after rst deasserts, the block SHALL behave as IDLE (start sampled normally).

Verification
REQ-029 Reset: rst=1 mid-frame -> all outputs 0 same cycle without clk edge; after release start frame completes normally.
REQ-030 Frame load: start, then ser_in 0,1,1,1, 0,1,0,1, 0 -> valid after 9 cycles, nibbl1=4'b1110, nibbl2=4'b1010, CIN=0, busy=0.
REQ-031 Hold/handshake: ack held 0 for 5 cycles in HOLD -> valid=1 and operands unchanged; ack=1 one cycle -> valid=0 next cycle, operands retained.
REQ-032 Ignored controls: start pulsed at bit 4 of a frame and ack pulsed during SHIFT -> frame completes at cycle 9 with correct data, counter undisturbed.
REQ-033 Back-to-back: start held 1, frames 1,1,0,0,0,0,0,0,0 then 0,0,0,1,0,1,0,1,1 with ack in HOLD -> nibbl1=4'b0011/nibbl2=0/CIN=0, then nibbl1=4'b1000/nibbl2=4'b1010/CIN=1, one IDLE cycle between.
REQ-034 Simultaneous: start=1 and ack=1 in HOLD -> IDLE, busy=0 next cycle, SHIFT entered only on following start edge.

Source files
------------

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - serial-to-parallel operand loader feeding an adder stage.
// Captures one LSB-first frame (nibbl1, nibbl2, CIN) and holds it until acknowledged.
module operand_loader #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ser_in,
    input  logic             ack,
    output logic [WIDTH-1:0] nibbl1,
    output logic [WIDTH-1:0] nibbl2,
    output logic             CIN,
    output logic             valid,
    output logic             busy
);
    localparam int FRAME = 2 * WIDTH + 1;
    localparam int CW    = $clog2(FRAME);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [FRAME-1:0] sreg;
    logic [FRAME-1:0] sreg_nxt;
    logic             last_bit;

    assign last_bit = (cnt == CW'(FRAME - 1));
    // New bits enter at the top so bit 0 of the frame ends up at sreg[0].
    assign sreg_nxt = {ser_in, sreg[FRAME-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = HOLD;
            HOLD:    if (ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid = (state == HOLD);
        busy  = (state == SHIFT);
    end

    // Operands are loaded in parallel only on the final bit so they never ripple.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            sreg   <= '0;
            nibbl1 <= '0;
            nibbl2 <= '0;
            CIN    <= 1'b0;
        end else if (state == SHIFT) begin
            sreg <= sreg_nxt;
            if (last_bit) begin
                cnt    <= '0;
                nibbl1 <= sreg_nxt[WIDTH-1:0];
                nibbl2 <= sreg_nxt[2*WIDTH-1:WIDTH];
                CIN    <= sreg_nxt[2*WIDTH];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
